uart_boot_loader: RTL and testbench
===================================

// Module: uart_boot_loader
// PURPOSE
//  Receives a program image over a UART 8N1 serial line and writes it byte-by-byte into
//  Instruction_Memory through the slave wrapper's boot_wr_en/boot_wr_addr/boot_wr_data port.
//  Holds the CPU core in reset until it has received a valid image, then releases it.
//  Frame format: 0xA5 sync, LEN_LO, LEN_HI (byte count, little-endian), LEN payload bytes,
//  then an 8-bit additive checksum of the payload.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  system clock frequency.
//  BAUD         115_200     UART bit rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (localparam, integer division).
//  BASE_ADDR    32'h0       boot_wr_addr value for payload byte 0.
//  MAX_BYTES    4096        largest accepted LEN. A larger LEN is an error.
// PORTS
//  clk           in   1   system clock, rising edge.
//  reset         in   1   asynchronous, active-low reset.
//  uart_rx       in   1   serial input, idle high. Asynchronous to clk.
//  boot_wr_en    out  1   1-cycle write strobe to Instruction_Memory.
//  boot_wr_addr  out  32  byte address of the write.
//  boot_wr_data  out  8   byte to write.
//  boot_busy     out  1   a frame is in progress (states LEN_LO..CSUM).
//  boot_done     out  1   valid image loaded. Sticky until reset.
//  boot_err      out  1   framing, length or checksum error. Cleared by the next 0xA5 sync byte.
//  cpu_hold      out  1   1 = keep the core in reset. Deasserted only in DONE.
// BEHAVIOUR
//  Reset values: boot_wr_en=0, boot_wr_addr=BASE_ADDR, boot_wr_data=0, boot_busy=0,
//   boot_done=0, boot_err=0, cpu_hold=1. Receiver and FSM go to IDLE. The rx synchroniser resets to 1.
//  Input sync: uart_rx passes through a 2-flop synchroniser. All sampling uses the synchronised copy.
//  Receiver:
//   - A falling edge starts a bit counter. At CLKS_PER_BIT/2 the start bit is re-sampled.
//   - If it reads 1, the edge was a glitch: return to idle and emit no byte.
//   - The 8 data bits are sampled LSB first, each CLKS_PER_BIT after the previous sample (mid-bit).
//   - The stop bit is then sampled. Stop=1: rx_valid pulses for 1 cycle with rx_byte.
//   - Stop=0: framing error. rx_ferr pulses, no rx_valid, and the receiver waits for the line to go high.
//  Main FSM: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
//   - IDLE:   rx_byte==0xA5 -> LEN_LO. Any other byte is ignored.
//   - LEN_LO: capture len[7:0] -> LEN_HI.
//   - LEN_HI: capture len[15:8]. len==0 or len>MAX_BYTES -> ERR. Otherwise clear idx and sum -> DATA.
//   - DATA:   on each rx_valid, in the next cycle boot_wr_en=1, boot_wr_addr=BASE_ADDR+idx
//             (32-bit, wraps modulo 2^32), boot_wr_data=byte. Then sum+=byte (mod 256) and idx++.
//             idx==len after the increment -> CSUM.
//   - CSUM:   byte==sum -> DONE (boot_done=1, cpu_hold=0). Otherwise -> ERR.
//   - DONE:   terminal. All further UART traffic is ignored. Only reset leaves DONE.
//   - ERR:    boot_err=1, cpu_hold=1. A 0xA5 byte clears boot_err -> LEN_LO. Other bytes are ignored.
//   - An rx_ferr in any state other than DONE or IDLE -> ERR. An rx_ferr in IDLE is ignored.
//  Write timing:
//   - boot_wr_en is high exactly 1 cycle per payload byte. Latency from rx_valid is 1 clk.
//   - boot_wr_addr/boot_wr_data are valid while boot_wr_en=1 and hold their values otherwise.
//   - At most one write per byte time, so Instruction_Memory needs no back-pressure.
//  Boundaries:
//   - len==1 is valid.
//   - len==MAX_BYTES is valid. len==MAX_BYTES+1 -> ERR with no writes issued.
//   - Reset mid-frame returns every output to its reset value. Bytes already written are not undone.
//   - A 0xA5 inside DATA is payload, not a resync.
// TESTING  (CLK_FREQ_HZ=1_000_000, BAUD=100_000 -> 10 clk/bit, BASE_ADDR=32'h100)
//  1. Send A5 03 00 11 22 33 66 -> writes (100,11),(101,22),(102,33), each strobe 1 cycle;
//     then boot_done=1, cpu_hold=0, boot_err=0.
//  2. Send A5 02 00 01 02 00 (bad checksum) -> 2 writes, boot_err=1, cpu_hold=1, boot_done=0.
//     Then send A5 01 00 7F 7F -> boot_err=0, write (100,7F), boot_done=1.
//  3. Send A5 01 10 (len=0x1001 > 4096) -> ERR, no boot_wr_en pulses.
//     Send A5 00 00 -> ERR (len 0).
//  4. Send byte 0x55 with stop bit=0 inside DATA -> ERR, no write for that byte.
//     Pull uart_rx low for 3 clks in IDLE -> no byte received, state stays IDLE.
//  5. Assert reset during payload byte 2 of test 1 -> all outputs at reset values
//     the next cycle, no later writes. Resend the full frame -> boot_done=1.
//  6. After DONE, send A5 01 00 AA AA -> no writes, boot_done stays 1.

Source files
------------

// File: rtl/uart_boot_loader.sv
// UART 8N1 boot loader: receives a sync/length/payload/checksum frame and streams the
// payload into instruction memory, holding the core in reset until a good image lands.
module uart_boot_loader #(
    parameter int          CLK_FREQ_HZ = 50_000_000,
    parameter int          BAUD        = 115_200,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          MAX_BYTES   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        boot_wr_en,
    output logic [31:0] boot_wr_addr,
    output logic [7:0]  boot_wr_data,
    output logic        boot_busy,
    output logic        boot_done,
    output logic        boot_err,
    output logic        cpu_hold,
    output logic [2:0]  boot_state
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT - 1);
    localparam logic [16:0]   MAX_LEN  = 17'(MAX_BYTES);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    logic            rx_meta, rx_sync;
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            sample;
    logic            rx_valid, rx_ferr;
    logic [7:0]      rx_byte;

    state_t          state, state_next;
    logic [15:0]     len_q, idx, idx_next, len_full;
    logic [7:0]      sum;
    logic            len_bad;

    // Receiver sampling points: half a bit into the start bit, then one full bit apart.
    assign sample = ((rx_state == RX_START) && (cnt == HALF_CNT)) ||
                    (((rx_state == RX_DATA) || (rx_state == RX_STOP)) && (cnt == LAST_CNT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_state <= rx_next;
            if (sample || (rx_state == RX_IDLE) || (rx_state == RX_WAIT))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if ((rx_state == RX_START) && sample)
                bit_cnt <= '0;
            if ((rx_state == RX_DATA) && sample) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (sample) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (sample && (bit_cnt == 3'd7)) rx_next = RX_STOP;
            RX_STOP:  if (sample) rx_next = rx_sync ? RX_IDLE : RX_WAIT;
            RX_WAIT:  if (rx_sync) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // rx_valid / rx_ferr are single-cycle pulses with no ready: the frame FSM must
    // consume every byte in the cycle it is presented, which it always can.
    always_comb begin
        rx_valid = (rx_state == RX_STOP) && sample && rx_sync;
        rx_ferr  = (rx_state == RX_STOP) && sample && !rx_sync;
        rx_byte  = shift;
    end

    assign len_full = {rx_byte, len_q[7:0]};
    assign len_bad  = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN);
    assign idx_next = idx + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (rx_valid && (rx_byte == 8'hA5)) state_next = S_LEN_LO;
            S_LEN_LO: if (rx_valid) state_next = S_LEN_HI;
            S_LEN_HI: if (rx_valid) state_next = len_bad ? S_ERR : S_DATA;
            S_DATA:   if (rx_valid && (idx_next == len_q)) state_next = S_CSUM;
            S_CSUM:   if (rx_valid) state_next = (rx_byte == sum) ? S_DONE : S_ERR;
            S_DONE:   state_next = S_DONE;
            S_ERR:    if (rx_valid && (rx_byte == 8'hA5)) state_next = S_LEN_LO;
            default:  state_next = S_IDLE;
        endcase
        // A broken frame mid-flight aborts it; idle-line noise and a finished image do not.
        if (rx_ferr && (state != S_IDLE) && (state != S_DONE))
            state_next = S_ERR;
    end

    always_comb begin
        boot_busy  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CSUM);
        boot_done  = (state == S_DONE);
        boot_err   = (state == S_ERR);
        cpu_hold   = (state != S_DONE);
        boot_state = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q        <= '0;
            idx          <= '0;
            sum          <= '0;
            boot_wr_en   <= 1'b0;
            boot_wr_addr <= BASE_ADDR;
            boot_wr_data <= '0;
        end else begin
            boot_wr_en <= 1'b0;
            if ((state == S_LEN_LO) && rx_valid)
                len_q[7:0] <= rx_byte;
            if ((state == S_LEN_HI) && rx_valid) begin
                len_q[15:8] <= rx_byte;
                idx         <= '0;
                sum         <= '0;
            end
            if ((state == S_DATA) && rx_valid) begin
                boot_wr_en   <= 1'b1;
                boot_wr_addr <= BASE_ADDR + {16'd0, idx};
                boot_wr_data <= rx_byte;
                sum          <= sum + rx_byte;
                idx          <= idx_next;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frames plus random frames, checked against a
// frame-level model that predicts the write stream and the done/err/busy flags.
module tb_uart_boot_loader;

    localparam int          CPB  = 10;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          MAX  = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rx = 1'b1;
    logic        boot_wr_en;
    logic [31:0] boot_wr_addr;
    logic [7:0]  boot_wr_data;
    logic        boot_busy, boot_done, boot_err, cpu_hold;
    logic [2:0]  boot_state;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD(100_000),
        .BASE_ADDR(BASE),
        .MAX_BYTES(MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .uart_rx(uart_rx),
        .boot_wr_en(boot_wr_en),
        .boot_wr_addr(boot_wr_addr),
        .boot_wr_data(boot_wr_data),
        .boot_busy(boot_busy),
        .boot_done(boot_done),
        .boot_err(boot_err),
        .cpu_hold(cpu_hold),
        .boot_state(boot_state)
    );

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];

    bit         m_done, m_err, m_busy;
    logic [7:0] m_frame[$];

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write strobe cycle must match the next predicted (addr,data) pair.
    always @(negedge clk) begin
        if (reset && boot_wr_en) begin
            if (exp_q.size() == 0)
                check("wr_unexpected_pending", 40'(exp_q.size()), 40'd1);
            else
                check("wr", {boot_wr_addr, boot_wr_data}, exp_q.pop_front());
        end
    end

    task automatic model_reset();
        exp_q.delete();
        m_frame.delete();
        m_done = 0;
        m_err  = 0;
        m_busy = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good_stop);
        int n, len;
        logic [7:0] s;
        if (m_done) return;
        if (!good_stop) begin
            if (m_busy) begin
                m_busy = 0;
                m_err  = 1;
            end
            return;
        end
        if (!m_busy) begin
            if (b == 8'hA5) begin
                m_busy = 1;
                m_err  = 0;
                m_frame.delete();
            end
            return;
        end
        m_frame.push_back(b);
        n = m_frame.size();
        len = (n >= 2) ? {m_frame[1], m_frame[0]} : 0;
        if (n == 2 && (len == 0 || len > MAX)) begin
            m_busy = 0;
            m_err  = 1;
        end else if (n > 2 && n <= len + 2) begin
            exp_q.push_back({BASE + 32'(n - 3), b});
        end else if (n > 2 && n == len + 3) begin
            s = 8'd0;
            for (int i = 2; i < len + 2; i++) s = s + m_frame[i];
            m_busy = 0;
            if (s == b) m_done = 1;
            else        m_err  = 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        model_byte(b, stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i], 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_en"}, boot_wr_en, 1'b0);
        check({tag, "_wr_addr"}, boot_wr_addr, BASE);
        check({tag, "_wr_data"}, boot_wr_data, 8'h00);
        check({tag, "_busy"}, boot_busy, 1'b0);
        check({tag, "_done"}, boot_done, 1'b0);
        check({tag, "_err"}, boot_err, 1'b0);
        check({tag, "_hold"}, cpu_hold, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        uart_rx = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_busy"}, boot_busy, m_busy);
        check({tag, "_done"}, boot_done, m_done);
        check({tag, "_err"}, boot_err, m_err);
        check({tag, "_hold"}, cpu_hold, !m_done);
        check({tag, "_pending"}, 40'(exp_q.size()), 40'd0);
    endtask

    initial begin
        logic [7:0] seq[$];
        int len, k, noise;
        bit bad_sum, inject;
        logic [7:0] s, b;

        do_reset();

        // Good three-byte image
        seq = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
        send_seq(seq);
        check_status("t1");

        // Bad checksum, then recovery by a fresh sync
        do_reset();
        seq = '{8'hA5};
        send_seq(seq);
        check_status("t2_sync");
        seq = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h00};
        send_seq(seq);
        check_status("t2_bad");
        seq = '{8'hA5, 8'h01, 8'h00, 8'h7F, 8'h7F};
        send_seq(seq);
        check_status("t2_good");

        // Length limits
        do_reset();
        seq = '{8'hA5, 8'h01, 8'h10};
        send_seq(seq);
        check_status("t3_over");
        seq = '{8'hA5, 8'h00, 8'h00};
        send_seq(seq);
        check_status("t3_zero");
        seq = '{8'hA5, 8'h00, 8'h10};
        send_seq(seq);
        check_status("t3_max");

        // Framing error in payload
        do_reset();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h11};
        send_seq(seq);
        send_byte(8'h55, 1'b0);
        check_status("t4_ferr");

        // Short low glitch right before a real frame must not swallow the sync byte
        do_reset();
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        seq = '{8'hA5, 8'h01, 8'h00, 8'h3C, 8'h3C};
        send_seq(seq);
        check_status("t4_glitch");

        // Reset in the middle of payload byte 2
        do_reset();
        seq = '{8'hA5, 8'h03, 8'h00, 8'h11};
        send_seq(seq);
        uart_rx = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_vals("t5_mid");
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        seq = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
        send_seq(seq);
        check_status("t5_resend");

        // Traffic after a finished load is ignored
        seq = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hAA};
        send_seq(seq);
        check_status("t6_after_done");

        // Random frames with noise, corrupted checksums and framing errors
        for (int it = 0; it < 15; it++) begin
            do_reset();
            noise = $urandom_range(0, 2);
            for (int i = 0; i < noise; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, 1'b1);
            end
            len     = $urandom_range(1, 5);
            bad_sum = ($urandom_range(0, 3) == 0);
            inject  = ($urandom_range(0, 5) == 0);
            k       = $urandom_range(0, len - 1);
            seq = '{8'hA5, 8'(len), 8'h00};
            send_seq(seq);
            s = 8'd0;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                s = s + b;
                send_byte(b, !(inject && i == k));
            end
            send_byte(bad_sum ? s + 8'd1 : s, 1'b1);
            check_status("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
